// File: rtl/tlc_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tlc_fsm
// Purpose  : Highway / farm-road traffic-light controller. It sits upstream of
//            the short/long interval timer. It issues the timer restart
//            strobes (trS, trL), consumes the timeout flags (tS, tL) and
//            synchronises the farm-road car sensor. All outputs are
//            registered.
// Options  : PED_REQ_EN - when defined, adds the ped_req input and the walk
//            output for pedestrian requests.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_fsm #(
    // Synchroniser depth on the car sensor. The legal range is 2..4.
    parameter int SYNC_STAGES     = 2,
    // 1: car=1 means a car is waiting. 0: the sensor input is active-low.
    parameter int CAR_ACTIVE_HIGH = 1
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic       car,
    input  logic       tS,
    input  logic       tL,
    output logic       trS,
    output logic       trL,
    output logic [1:0] hwy,
    output logic [1:0] farm,
    output logic [1:0] state
`ifdef PED_REQ_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    // Light encoding shared by both roads.
    localparam logic [1:0] c_RED    = 2'b00;
    localparam logic [1:0] c_YELLOW = 2'b01;
    localparam logic [1:0] c_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_HG = 2'd0,   // highway green, farm red
        ST_HY = 2'd1,   // highway yellow, farm red
        ST_FG = 2'd2,   // highway red, farm green
        ST_FY = 2'd3    // highway red, farm yellow
    } state_t;

    // ------------------------------------------------------------------------
    // Car sensor: polarity normalisation, then a synchroniser chain.
    // ------------------------------------------------------------------------
    logic                   w_car_in;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_car_s;

    generate
        if (CAR_ACTIVE_HIGH != 0) begin : g_car_active_high
            assign w_car_in = car;
        end else begin : g_car_active_low
            assign w_car_in = ~car;
        end
    endgenerate

    // Shift the raw sensor through SYNC_STAGES flops before the FSM uses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_car_in};
        end
    end

    assign w_car_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Controller state and registered outputs.
    // ------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_hwy;
    logic [1:0] w_hwy_nxt;
    logic [1:0] r_farm;
    logic [1:0] w_farm_nxt;
    logic       r_trs;
    logic       w_trs_nxt;
    logic       r_trl;
    logic       w_trl_nxt;
    // r_armed stays low until the timer has consumed the latest restart
    // pulse. This ensures that timeout flags left over from the previous
    // interval cannot cause a transition.
    logic       r_armed;
    logic       w_armed_nxt;
    // r_start is high only between reset release and the first edge. It
    // fires the launch pulse for the first HG long interval, because a
    // timer that has just come out of reset has no interval running.
    logic       r_start;
    logic       w_start_nxt;

    // Exit conditions. With the pedestrian option enabled, a pending request
    // counts as a car at HG. The request also holds FG until the long
    // interval expires.
    logic       w_hg_go;
    logic       w_fg_exit;

`ifdef PED_REQ_EN
    logic       r_ped;
    logic       w_ped_nxt;
    logic       r_walk;
    logic       w_walk_nxt;

    assign w_hg_go   = (w_car_s || r_ped) && tL;
    assign w_fg_exit = r_ped ? tL : (!w_car_s || tL);
`else
    assign w_hg_go   = w_car_s && tL;
    assign w_fg_exit = !w_car_s || tL;
`endif

    // Next-state logic, restart-pulse generation, arming and light decode.
    always_comb begin
        w_state_nxt = r_state;
        w_trs_nxt   = 1'b0;
        w_trl_nxt   = 1'b0;
        w_armed_nxt = r_armed;
        w_start_nxt = r_start;
`ifdef PED_REQ_EN
        w_ped_nxt   = r_ped | ped_req;
`endif

        if (r_start) begin
            // Launch the first HG long interval.
            w_trl_nxt   = 1'b1;
            w_start_nxt = 1'b0;
            w_armed_nxt = 1'b0;
        end else if (r_trs || r_trl) begin
            // The timer consumes the pulse on this edge. Timeouts seen from
            // now on belong to the new interval.
            w_armed_nxt = 1'b1;
        end else if (r_armed) begin
            case (r_state)
                ST_HG: begin
                    if (w_hg_go) begin
                        w_state_nxt = ST_HY;
                        w_trs_nxt   = 1'b1;
                        w_armed_nxt = 1'b0;
                    end
                end
                ST_HY: begin
                    if (tS) begin
                        w_state_nxt = ST_FG;
                        w_trl_nxt   = 1'b1;
                        w_armed_nxt = 1'b0;
                    end
                end
                ST_FG: begin
                    if (w_fg_exit) begin
                        w_state_nxt = ST_FY;
                        w_trs_nxt   = 1'b1;
                        w_armed_nxt = 1'b0;
`ifdef PED_REQ_EN
                        // The request has been served. A request that arrives
                        // on this same edge is kept for the next cycle.
                        w_ped_nxt   = ped_req;
`endif
                    end
                end
                ST_FY: begin
                    if (tS) begin
                        w_state_nxt = ST_HG;
                        w_trl_nxt   = 1'b1;
                        w_armed_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_HG;
                end
            endcase
        end

        // The lights follow the next state. They are therefore registered
        // together with it, and the two roads cannot both be non-red.
        w_hwy_nxt  = c_RED;
        w_farm_nxt = c_RED;
        case (w_state_nxt)
            ST_HG: w_hwy_nxt  = c_GREEN;
            ST_HY: w_hwy_nxt  = c_YELLOW;
            ST_FG: w_farm_nxt = c_GREEN;
            ST_FY: w_farm_nxt = c_YELLOW;
            default: begin
                w_hwy_nxt  = c_RED;
                w_farm_nxt = c_RED;
            end
        endcase

`ifdef PED_REQ_EN
        w_walk_nxt = (w_state_nxt == ST_FG) && w_ped_nxt;
`endif
    end

    // State, lights, pulses and arming register. Reset forces HG at once and
    // cancels any pulse in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HG;
            r_hwy   <= c_GREEN;
            r_farm  <= c_RED;
            r_trs   <= 1'b0;
            r_trl   <= 1'b0;
            r_armed <= 1'b0;
            r_start <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hwy   <= w_hwy_nxt;
            r_farm  <= w_farm_nxt;
            r_trs   <= w_trs_nxt;
            r_trl   <= w_trl_nxt;
            r_armed <= w_armed_nxt;
            r_start <= w_start_nxt;
        end
    end

`ifdef PED_REQ_EN
    // Sticky pedestrian request flag and walk indicator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ped  <= 1'b0;
            r_walk <= 1'b0;
        end else begin
            r_ped  <= w_ped_nxt;
            r_walk <= w_walk_nxt;
        end
    end

    assign walk = r_walk;
`endif

    assign trS   = r_trs;
    assign trL   = r_trl;
    assign hwy   = r_hwy;
    assign farm  = r_farm;
    assign state = r_state;

    // ------------------------------------------------------------------------
    // Safety properties.
    // ------------------------------------------------------------------------
    a_one_trigger : assert property (@(posedge clk) disable iff (!reset)
        !(r_trs && r_trl));

    a_one_road_moving : assert property (@(posedge clk) disable iff (!reset)
        (r_hwy == c_RED) || (r_farm == c_RED));

    a_trs_single : assert property (@(posedge clk) disable iff (!reset)
        r_trs |=> !r_trs);

    a_trl_single : assert property (@(posedge clk) disable iff (!reset)
        r_trl |=> !r_trl);

endmodule
`default_nettype wire

// File: tb/tb_tlc_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_fsm
// Purpose  : Scoreboard bench for tlc_fsm. Each restart pulse from the DUT is
//            an output event. The stimulus pushes the expected event (cycle
//            number since reset release, state, lights and pulse) and the
//            monitor pops and compares it. A small interval-timer model
//            produces tS and tL with svalue=5 and lvalue=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_fsm;

    localparam int SVALUE = 5;
    localparam int LVALUE = 10;

    localparam logic [1:0] HG = 2'd0;
    localparam logic [1:0] HY = 2'd1;
    localparam logic [1:0] FG = 2'd2;
    localparam logic [1:0] FY = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       car = 1'b0;
    logic       tS;
    logic       tL;
    logic       trS;
    logic       trL;
    logic [1:0] hwy;
    logic [1:0] farm;
    logic [1:0] state;
`ifdef PED_REQ_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlc_fsm #(.SYNC_STAGES(2), .CAR_ACTIVE_HIGH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .car   (car),
        .tS    (tS),
        .tL    (tL),
        .trS   (trS),
        .trL   (trL),
        .hwy   (hwy),
        .farm  (farm),
        .state (state)
`ifdef PED_REQ_EN
        ,
        .ped_req (ped_req),
        .walk    (walk)
`endif
    );

    // Cycle counter: number of rising edges since the last reset release.
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Interval timer model. A restart pulse starts counting. The flag rises
    // once the count reaches the interval and stays high until the next
    // restart.
    int   s_cnt;
    int   l_cnt;
    logic s_run;
    logic l_run;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cnt <= 0; l_cnt <= 0; s_run <= 1'b0; l_run <= 1'b0;
        end else begin
            if (trS) begin
                s_run <= 1'b1; s_cnt <= 1;
            end else if (s_run && s_cnt < SVALUE) begin
                s_cnt <= s_cnt + 1;
            end
            if (trL) begin
                l_run <= 1'b1; l_cnt <= 1;
            end else if (l_run && l_cnt < LVALUE) begin
                l_cnt <= l_cnt + 1;
            end
        end
    end

    // Optional override that forces tS=tL=1 throughout each pulse cycle,
    // which is the first cycle after a state entry.
    logic force_en = 1'b0;
    logic force_t  = 1'b0;
    always @(negedge clk) force_t = force_en && (trS || trL);

    assign tS = (s_run && s_cnt == SVALUE) || force_t;
    assign tL = (l_run && l_cnt == LVALUE) || force_t;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [1:0] hw;
        logic [1:0] fm;
        logic       ts;
        logic       tl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [1:0] hwy_of(input logic [1:0] st);
        case (st)
            2'd0:    return 2'b10;
            2'd1:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] farm_of(input logic [1:0] st);
        case (st)
            2'd2:    return 2'b10;
            2'd3:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push(input int c, input logic [1:0] st, input logic ts, input logic tl);
        exp_t e;
        e.cyc = c; e.st = st; e.hw = hwy_of(st); e.fm = farm_of(st);
        e.ts = ts; e.tl = tl;
        sb.push_back(e);
    endtask

    // Monitor: invariants every cycle, plus a scoreboard pop on every pulse.
    always @(negedge clk) begin
        checks++;
        if (trS && trL) begin
            failures++;
            $display("FAIL both_pulses cyc=%0d trS=%b trL=%b required never both high", cyc, trS, trL);
        end
        checks++;
        if (hwy != 2'b00 && farm != 2'b00) begin
            failures++;
            $display("FAIL both_roads_go cyc=%0d hwy=%b farm=%b required one red", cyc, hwy, farm);
        end
        if (trS || trL) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d state=%0d trS=%b trL=%b required no pulse",
                         cyc, state, trS, trL);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || state !== mon_e.st || hwy !== mon_e.hw ||
                    farm !== mon_e.fm || trS !== mon_e.ts || trL !== mon_e.tl) begin
                    failures++;
                    $display("FAIL pulse_event got cyc=%0d st=%0d hwy=%b farm=%b trS=%b trL=%b required cyc=%0d st=%0d hwy=%b farm=%b trS=%b trL=%b",
                             cyc, state, hwy, farm, trS, trL,
                             mon_e.cyc, mon_e.st, mon_e.hw, mon_e.fm, mon_e.ts, mon_e.tl);
                end
            end
        end
    end

    // Direct comparison used for reset and steady-state checks.
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Wait until the counter reaches n. Returns at a falling edge.
    task automatic wait_to(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout got cyc=%0d required %0d", cyc, n);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {2'b00, state}, {2'b00, HG});
        chk("reset_hwy",   {2'b00, hwy},   4'h2);
        chk("reset_farm",  {2'b00, farm},  4'h0);
        chk("reset_trS",   {3'b000, trS},  4'h0);
        chk("reset_trL",   {3'b000, trL},  4'h0);

        // No car: start-up pulse only, then HG is held for 100 cycles.
        push(1, HG, 1'b0, 1'b1);
        reset = 1'b1;
        wait_to(50);
        chk("hold_state_50", {2'b00, state}, {2'b00, HG});
        chk("hold_hwy_50",   {2'b00, hwy},   4'h2);
        wait_to(100);
        chk("hold_state_100", {2'b00, state}, {2'b00, HG});
        chk("hold_farm_100",  {2'b00, farm},  4'h0);

        // Car present, with tS=tL forced on every post-entry cycle. Reset is
        // asserted asynchronously during the FG entry pulse.
        #2 reset = 1'b0;
        car = 1'b1;
        force_en = 1'b1;
        repeat (2) @(negedge clk);
        push(1,  HG, 1'b0, 1'b1);
        push(12, HY, 1'b1, 1'b0);
        push(18, FG, 1'b0, 1'b1);
        reset = 1'b1;
        wait_to(18);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", {2'b00, state}, {2'b00, HG});
        chk("async_rst_hwy",   {2'b00, hwy},   4'h2);
        chk("async_rst_farm",  {2'b00, farm},  4'h0);
        chk("async_rst_trS",   {3'b000, trS},  4'h0);
        chk("async_rst_trL",   {3'b000, trL},  4'h0);
        force_en = 1'b0;
        repeat (2) @(negedge clk);

        // Full cycle with the car held. The car then leaves during FG, which
        // gives an early exit to FY before tL.
        push(1,  HG, 1'b0, 1'b1);
        push(12, HY, 1'b1, 1'b0);
        push(18, FG, 1'b0, 1'b1);
        push(29, FY, 1'b1, 1'b0);
        push(35, HG, 1'b0, 1'b1);
        push(46, HY, 1'b1, 1'b0);
        push(52, FG, 1'b0, 1'b1);
        push(58, FY, 1'b1, 1'b0);
        push(64, HG, 1'b0, 1'b1);
        reset = 1'b1;
        wait_to(40);
        chk("mid_cycle_state", {2'b00, state}, {2'b00, HG});
        wait_to(55);
        car = 1'b0;
        wait_to(80);
        chk("final_state", {2'b00, state}, {2'b00, HG});
        chk("final_hwy",   {2'b00, hwy},   4'h2);

`ifdef PED_REQ_EN
        // Pedestrian request with no car: HG exits on the stale armed tL and
        // FG is held until tL with walk asserted.
        push(82, HY, 1'b1, 1'b0);
        push(88, FG, 1'b0, 1'b1);
        push(99, FY, 1'b1, 1'b0);
        push(105, HG, 1'b0, 1'b1);
        ped_req = 1'b1;
        wait_to(81);
        ped_req = 1'b0;
        wait_to(85);
        chk("walk_in_hy", {3'b000, walk}, 4'h0);
        wait_to(90);
        chk("walk_in_fg_90", {3'b000, walk}, 4'h1);
        wait_to(97);
        chk("walk_in_fg_97", {3'b000, walk}, 4'h1);
        wait_to(100);
        chk("walk_in_fy", {3'b000, walk}, 4'h0);
        wait_to(110);
`else
        wait_to(90);
`endif

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses got %0d unseen required 0 (next expected cyc=%0d)",
                     sb.size(), sb[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlc_fsm.md
Name: tlc_fsm

Overview:
Highway/farm-road traffic-light controller FSM that sits directly upstream of the short/long interval timer. It drives the timer's restart strobes (trS, trL), consumes its timeout flags (tS, tL), synchronises the farm-road car sensor, and produces registered light outputs for both roads. One clock domain; all outputs are registered.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the car-sensor synchroniser; legal range 2..4.
CAR_ACTIVE_HIGH, 1, 1 means car=1 signals a waiting car; 0 means the input is inverted before the synchroniser.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
car  input  1  raw farm-road vehicle sensor, asynchronous to clk.
tS  input  1  short-interval timeout from the timer.
tL  input  1  long-interval timeout from the timer.
trS  output  1  one-cycle pulse that restarts the timer's short interval.
trL  output  1  one-cycle pulse that restarts the timer's long interval.
hwy  output  2  highway light: 2'b00 red, 2'b01 yellow, 2'b10 green.
farm  output  2  farm-road light, same encoding.
state  output  2  current state: HG=0, HY=1, FG=2, FY=3.

Behaviour:
- Reset (reset=0, asynchronous): state=HG, hwy=green, farm=red, trS=0, trL=0, armed=0, synchroniser flops=0, start=1.
- Start-up: at the first clk edge after reset releases, trL=1 for exactly one cycle and start clears. This launches the first HG long interval, because timer reset leaves its trackers idle.
- car_s is car (inverted when CAR_ACTIVE_HIGH=0) after SYNC_STAGES flops. The FSM uses only car_s.
- Arming rule: entering a state, or the start-up pulse, issues one trigger pulse and clears armed. armed sets on the edge on which the pulse is high, because the timer consumes the pulse on that edge. tS and tL are ignored while armed=0. This masks stale timeout flags. The earliest transition is therefore 2 cycles after state entry.
- Transitions are evaluated only when armed=1. Each transition updates state and the lights on the same edge, clears armed, and drives the named trigger high for the next cycle:
  HG -> HY when car_s && tL; pulse trS.
  HY -> FG when tS; pulse trL.
  FG -> FY when !car_s || tL; pulse trS.
  FY -> HG when tS; pulse trL.
- Lights by state: HG hwy=green farm=red; HY hwy=yellow farm=red; FG hwy=red farm=green; FY hwy=red farm=yellow. At no time are both roads non-red.
- HG holds indefinitely with no car, even after tL fires. The timer keeps running; the FSM acts on the next tL seen with car_s=1.
- tS and tL high together: only the flag named for the current state matters; the other is ignored.
- trS and trL are never high in the same cycle. No pulse lasts more than 1 cycle.
- Reset asserted mid-operation returns immediately to HG and aborts any pending pulse. Start-up behaviour then repeats.
- FG exit on !car_s takes effect in the first armed cycle. Minimum FG dwell is 2 cycles.

Optional Feature:
PED_REQ_EN: when defined, adds input ped_req (synchronous pulse) and output walk.
- ped_req latches a sticky request flag.
- The flag acts as car_s=1 for the HG exit condition and holds FG until tL, ignoring !car_s.
- walk=1 throughout FG when the request caused or extended that FG. The flag and walk clear on FG->FY.
- Undefined: no extra ports; behaviour is exactly as above.

Test Plan:
- Reset release, car=0, bench timer model svalue=5 lvalue=10 -> trL pulses in cycle 1 after release; state stays HG for 100 cycles; hwy=2'b10 and farm=2'b00 throughout.
- Hold car=1 from reset release -> HG->HY at the first armed tL (about 11 cycles); trS pulses for 1 cycle; HY lasts about 7 cycles; then FG with a trL pulse.
- Car stays 1 -> FG->FY on tL after about 12 cycles; FY->HG on tS; full cycle HG,HY,FG,FY,HG with exactly one trigger pulse per transition.
- In FG, drop car to 0 -> FY entered SYNC_STAGES+1 cycles later, before tL; trS pulse follows.
- Force tS=tL=1 on the first cycle after each state entry -> no transition (armed guard), state unchanged.
- Assert reset=0 asynchronously mid-FG -> outputs go to HG lights and trS=trL=0 immediately, without waiting for a clock edge; after release, the trL start-up pulse repeats. With PED_REQ_EN and car=0, a ped_req pulse in HG -> HY on the next armed tL and walk=1 throughout FG.
